// File: rtl/rs_alu_station_if.sv
// Insert, CDB snoop and ALU result bundle of the ALU reservation station.
interface rs_alu_station_if #(
  parameter int ROB_SIZE_BIT = 4,
  parameter int RS_TYPE_BIT  = 4,
  parameter int NUM_CDB      = 2
);
  logic                            rs_full;
  logic                            inst_input;
  logic [RS_TYPE_BIT-1:0]          rs_type;
  logic [31:0]                     rs_r1_val, rs_r2_val;
  logic                            rs_r1_has_dep, rs_r2_has_dep;
  logic [ROB_SIZE_BIT-1:0]         rs_r1_dep, rs_r2_dep, rs_rob_id;
  logic [NUM_CDB-1:0]              cdb_ready;
  logic [NUM_CDB*ROB_SIZE_BIT-1:0] cdb_rob_id;
  logic [NUM_CDB*32-1:0]           cdb_value;
  logic                            alu_ready;
  logic [ROB_SIZE_BIT-1:0]         alu_rob_id;
  logic [31:0]                     alu_value;

  modport master (
    output inst_input, rs_type, rs_r1_val, rs_r2_val, rs_r1_has_dep, rs_r2_has_dep,
           rs_r1_dep, rs_r2_dep, rs_rob_id, cdb_ready, cdb_rob_id, cdb_value,
    input  rs_full, alu_ready, alu_rob_id, alu_value
  );
  modport slave (
    input  inst_input, rs_type, rs_r1_val, rs_r2_val, rs_r1_has_dep, rs_r2_has_dep,
           rs_r1_dep, rs_r2_dep, rs_rob_id, cdb_ready, cdb_rob_id, cdb_value,
    output rs_full, alu_ready, alu_rob_id, alu_value
  );
endinterface

// File: rtl/rs_alu_station.sv
// Reservation station with single-cycle integer ALU, CDB operand snooping and one issue per cycle.
// Define RS_OLDEST_FIRST_EN for age-matrix oldest-ready select; otherwise lowest-index ready wins.
module rs_alu_station #(
  parameter int RS_SIZE      = 8,
  parameter int RS_SIZE_BIT  = 3,
  parameter int ROB_SIZE_BIT = 4,
  parameter int RS_TYPE_BIT  = 4,
  parameter int NUM_CDB      = 2
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  input logic             clear,
  rs_alu_station_if.slave bus
);
  typedef struct packed {
    logic                    busy;
    logic [RS_TYPE_BIT-1:0]  op;
    logic                    r1_has_dep, r2_has_dep;
    logic [ROB_SIZE_BIT-1:0] r1_dep, r2_dep, rob_id;
    logic [31:0]             r1_val, r2_val;
  } entry_t;

  entry_t                  ent_q [RS_SIZE];
  entry_t                  ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]      busy, ready, sel;
  logic [RS_SIZE_BIT-1:0]  free_idx, sel_idx;
  logic                    ins_ok, any_sel;
  logic                    alu_ready_q;
  logic [ROB_SIZE_BIT-1:0] alu_rob_id_q;
  logic [31:0]             alu_value_q, res, a, b;

  // {hit, value}; iterating downward lets the lowest matching channel win
  function automatic logic [32:0] snoop(input logic [ROB_SIZE_BIT-1:0]         dep,
                                        input logic [NUM_CDB-1:0]              rdy,
                                        input logic [NUM_CDB*ROB_SIZE_BIT-1:0] ids,
                                        input logic [NUM_CDB*32-1:0]           vals);
    logic [32:0] r;
    r = '0;
    for (int k = NUM_CDB-1; k >= 0; k--)
      if (rdy[k] && ids[k*ROB_SIZE_BIT +: ROB_SIZE_BIT] == dep)
        r = {1'b1, vals[k*32 +: 32]};
    return r;
  endfunction

  always_comb begin
    free_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i]  = ent_q[i].busy;
      ready[i] = ent_q[i].busy && !ent_q[i].r1_has_dep && !ent_q[i].r2_has_dep;
    end
    for (int i = RS_SIZE-1; i >= 0; i--)
      if (!busy[i]) free_idx = RS_SIZE_BIT'(i);
  end

  assign bus.rs_full = &busy;
  assign ins_ok      = bus.inst_input && !bus.rs_full;

`ifdef RS_OLDEST_FIRST_EN
  // older_q[i][j]: entry j was already waiting when entry i was inserted
  logic [RS_SIZE-1:0] older_q [RS_SIZE];

  always_comb
    for (int i = 0; i < RS_SIZE; i++)
      sel[i] = ready[i] && !(|(older_q[i] & ready));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
    end else if (rdy_in && ins_ok && !clear) begin
      for (int r = 0; r < RS_SIZE; r++)
        if (RS_SIZE_BIT'(r) == free_idx) older_q[r] <= busy;
        else                             older_q[r][free_idx] <= 1'b0;
    end
  end
`else
  assign sel = ready & (~ready + 1'b1);
`endif

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (sel[i]) sel_idx = RS_SIZE_BIT'(i);
  end
  assign any_sel = |sel;

  always_comb begin
    logic [32:0] w1, w2;
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      w1 = snoop(ent_q[i].r1_dep, bus.cdb_ready, bus.cdb_rob_id, bus.cdb_value);
      w2 = snoop(ent_q[i].r2_dep, bus.cdb_ready, bus.cdb_rob_id, bus.cdb_value);
      if (ent_q[i].busy && ent_q[i].r1_has_dep && w1[32]) begin
        ent_d[i].r1_has_dep = 1'b0;
        ent_d[i].r1_val     = w1[31:0];
      end
      if (ent_q[i].busy && ent_q[i].r2_has_dep && w2[32]) begin
        ent_d[i].r2_has_dep = 1'b0;
        ent_d[i].r2_val     = w2[31:0];
      end
      if (sel[i]) ent_d[i].busy = 1'b0;
      if (ins_ok && free_idx == RS_SIZE_BIT'(i)) begin
        w1 = snoop(bus.rs_r1_dep, bus.cdb_ready, bus.cdb_rob_id, bus.cdb_value);
        w2 = snoop(bus.rs_r2_dep, bus.cdb_ready, bus.cdb_rob_id, bus.cdb_value);
        ent_d[i].busy       = 1'b1;
        ent_d[i].op         = bus.rs_type;
        ent_d[i].rob_id     = bus.rs_rob_id;
        ent_d[i].r1_dep     = bus.rs_r1_dep;
        ent_d[i].r2_dep     = bus.rs_r2_dep;
        ent_d[i].r1_has_dep = bus.rs_r1_has_dep && !w1[32];
        ent_d[i].r2_has_dep = bus.rs_r2_has_dep && !w2[32];
        ent_d[i].r1_val     = (bus.rs_r1_has_dep && w1[32]) ? w1[31:0] : bus.rs_r1_val;
        ent_d[i].r2_val     = (bus.rs_r2_has_dep && w2[32]) ? w2[31:0] : bus.rs_r2_val;
      end
      if (clear) ent_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    a   = ent_q[sel_idx].r1_val;
    b   = ent_q[sel_idx].r2_val;
    res = '0;
    case (int'(ent_q[sel_idx].op))
      0:  res = a + b;
      1:  res = a - b;
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = a << b[4:0];
      6:  res = a >> b[4:0];
      7:  res = $unsigned($signed(a) >>> b[4:0]);
      8:  res = {31'b0, $signed(a) < $signed(b)};
      9:  res = {31'b0, a < b};
      10: res = {31'b0, a == b};
      11: res = {31'b0, a != b};
      12: res = {31'b0, $signed(a) < $signed(b)};
      13: res = {31'b0, $signed(a) >= $signed(b)};
      14: res = {31'b0, a < b};
      15: res = {31'b0, a >= b};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      alu_ready_q  <= 1'b0;
      alu_rob_id_q <= '0;
      alu_value_q  <= '0;
    end else if (rdy_in) begin
      ent_q <= ent_d;
      if (clear) begin
        alu_ready_q <= 1'b0;
      end else begin
        alu_ready_q <= any_sel;
        if (any_sel) begin
          alu_rob_id_q <= ent_q[sel_idx].rob_id;
          alu_value_q  <= res;
        end
      end
    end
  end

  assign bus.alu_ready  = alu_ready_q;
  assign bus.alu_rob_id = alu_rob_id_q;
  assign bus.alu_value  = alu_value_q;
endmodule

// File: tb/tb_rs_alu_station.sv
// Directed-vector bench for rs_alu_station; expected results are hand-computed constants.
module tb_rs_alu_station;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear;
  int   n_cmp = 0;
  int   n_bad = 0;

  rs_alu_station_if #(.ROB_SIZE_BIT(4), .RS_TYPE_BIT(4), .NUM_CDB(2)) bus ();

  rs_alu_station #(.RS_SIZE(8), .RS_SIZE_BIT(3), .ROB_SIZE_BIT(4), .RS_TYPE_BIT(4), .NUM_CDB(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.inst_input = 1'b0;
    bus.cdb_ready  = '0;
    clear          = 1'b0;
  endtask

  task automatic set_ins(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic h1, input logic [3:0] d1, input logic h2,
                         input logic [3:0] d2, input logic [3:0] rob);
    bus.inst_input    = 1'b1;
    bus.rs_type       = op;
    bus.rs_r1_val     = v1;
    bus.rs_r2_val     = v2;
    bus.rs_r1_has_dep = h1;
    bus.rs_r1_dep     = d1;
    bus.rs_r2_has_dep = h2;
    bus.rs_r2_dep     = d2;
    bus.rs_rob_id     = rob;
  endtask

  task automatic bcast(input int ch, input logic [3:0] rob, input logic [31:0] val);
    bus.cdb_ready[ch]          = 1'b1;
    bus.cdb_rob_id[ch*4 +: 4]  = rob;
    bus.cdb_value[ch*32 +: 32] = val;
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [3:0] rob, input logic [31:0] val);
    expect_eq({tag, ".ready"}, {31'b0, bus.alu_ready}, {31'b0, rdy});
    if (rdy) begin
      expect_eq({tag, ".rob"}, {28'b0, bus.alu_rob_id}, {28'b0, rob});
      expect_eq({tag, ".value"}, bus.alu_value, val);
    end
  endtask

  logic [31:0] va [16] = '{32'hFFFFFFFF, 32'd3, 32'h0000F0F0, 32'h0000F0F0,
                           32'h0000FF00, 32'd1, 32'h80000000, 32'h80000000,
                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7,
                           32'd1, 32'd1, 32'd1, 32'd5};
  logic [31:0] vb [16] = '{32'd2, 32'd5, 32'h0000FF00, 32'h00000F00,
                           32'h00000FF0, 32'h00000024, 32'd31, 32'd4,
                           32'd1, 32'd1, 32'd7, 32'd7,
                           32'h80000000, 32'h80000000, 32'h80000000, 32'd6};
  logic [31:0] ve [16] = '{32'h00000001, 32'hFFFFFFFE, 32'h0000F000, 32'h0000FFF0,
                           32'h0000F0F0, 32'h00000010, 32'h00000001, 32'hF8000000,
                           32'd1, 32'd0, 32'd1, 32'd0,
                           32'd0, 32'd1, 32'd1, 32'd0};

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    set_ins(4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    bus.inst_input = 1'b0;
    bus.cdb_rob_id = '0;
    bus.cdb_value  = '0;
    step(); step();
    rst_in = 1'b0;
    expect_eq("reset.ready", {31'b0, bus.alu_ready}, 32'd0);
    expect_eq("reset.rob", {28'b0, bus.alu_rob_id}, 32'd0);
    expect_eq("reset.value", bus.alu_value, 32'd0);
    expect_eq("reset.full", {31'b0, bus.rs_full}, 32'd0);

    // ADD 5+7 -> ROB 3, then hold under rdy_in low
    set_ins(4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    step(); idle();
    chk_out("add.n", 1'b0, 4'd0, 32'd0);
    step();
    chk_out("add.n1", 1'b1, 4'd3, 32'd12);
    rdy_in = 1'b0;
    step();
    chk_out("add.frozen", 1'b1, 4'd3, 32'd12);
    rdy_in = 1'b1;
    step();
    chk_out("add.drop", 1'b0, 4'd0, 32'd0);

    // SUB waiting on ROB 6 via channel 1
    set_ins(4'd1, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd4);
    step(); idle();
    step();
    chk_out("sub.wait", 1'b0, 4'd0, 32'd0);
    bcast(1, 4'd6, 32'h10);
    step(); idle();
    chk_out("sub.bcast", 1'b0, 4'd0, 32'd0);
    step();
    chk_out("sub.result", 1'b1, 4'd4, 32'h0F);
    step();

    // Fill all entries on ROB 9, extra insert dropped, drain in order
    for (int i = 0; i < 8; i++) begin
      set_ins(4'd0, 32'd0, 32'(i), 1'b1, 4'd9, 1'b0, 4'd0, 4'(i));
      step();
    end
    idle();
    expect_eq("fill.full", {31'b0, bus.rs_full}, 32'd1);
    set_ins(4'd0, 32'd100, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
    step(); idle();
    expect_eq("fill.extra_full", {31'b0, bus.rs_full}, 32'd1);
    chk_out("fill.extra", 1'b0, 4'd0, 32'd0);
    bcast(0, 4'd9, 32'd0);
    step(); idle();
    expect_eq("fill.bcast_full", {31'b0, bus.rs_full}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_out($sformatf("drain%0d", i), 1'b1, 4'(i), 32'(i));
      if (i == 0) expect_eq("drain.full", {31'b0, bus.rs_full}, 32'd0);
    end
    step();
    chk_out("drain.end", 1'b0, 4'd0, 32'd0);

    // Same-cycle insert + channel-0 broadcast, SRA by 4
    set_ins(4'd7, 32'd0, 32'd4, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    bcast(0, 4'd2, 32'hFFFFFFFF);
    step(); idle();
    chk_out("sra.n", 1'b0, 4'd0, 32'd0);
    step();
    chk_out("sra.result", 1'b1, 4'd5, 32'hFFFFFFFF);

    // Back-to-back ALU op table
    for (int i = 0; i < 16; i++) begin
      set_ins(4'(i), va[i], vb[i], 1'b0, 4'd0, 1'b0, 4'd0, 4'(i));
      step();
      if (i > 0) chk_out($sformatf("op%0d", i-1), 1'b1, 4'(i-1), ve[i-1]);
    end
    idle();
    step();
    chk_out("op15", 1'b1, 4'd15, ve[15]);
    step();

    // Flush with a concurrent insert
    for (int i = 0; i < 3; i++) begin
      set_ins(4'd0, 32'd1, 32'd1, 1'b1, 4'd11, 1'b0, 4'd0, 4'(i));
      step();
    end
    set_ins(4'd0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    clear = 1'b1;
    step(); idle();
    expect_eq("clear.full", {31'b0, bus.rs_full}, 32'd0);
    chk_out("clear.n", 1'b0, 4'd0, 32'd0);
    step();
    chk_out("clear.n1", 1'b0, 4'd0, 32'd0);
    bcast(0, 4'd11, 32'd0);
    step(); idle();
    step();
    chk_out("clear.woken", 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      set_ins(4'd0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'(i));
      step();
    end
    idle();
    expect_eq("clear.seven", {31'b0, bus.rs_full}, 32'd0);
    set_ins(4'd0, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd7);
    step(); idle();
    expect_eq("clear.eight", {31'b0, bus.rs_full}, 32'd1);
    clear = 1'b1;
    step(); idle();
    expect_eq("clear.again", {31'b0, bus.rs_full}, 32'd0);

    // Select order: B (entry 1) and new C (entry 0) ready in the same cycle
    set_ins(4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd1);
    step(); idle();
    set_ins(4'd0, 32'h20, 32'd0, 1'b0, 4'd0, 1'b1, 4'd13, 4'd2);
    step(); idle();
    bcast(1, 4'd1, 32'h100);
    step(); idle();
    chk_out("age.wake", 1'b0, 4'd0, 32'd0);
    step();
    chk_out("age.a", 1'b1, 4'd1, 32'h100);
    set_ins(4'd0, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    bcast(0, 4'd13, 32'h30);
    step(); idle();
    chk_out("age.x", 1'b0, 4'd0, 32'd0);
    step();
`ifdef RS_OLDEST_FIRST_EN
    chk_out("age.first", 1'b1, 4'd2, 32'h50);
    step();
    chk_out("age.second", 1'b1, 4'd3, 32'd7);
`else
    chk_out("age.first", 1'b1, 4'd3, 32'd7);
    step();
    chk_out("age.second", 1'b1, 4'd2, 32'h50);
`endif
    step();
    chk_out("age.end", 1'b0, 4'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
